// File: rtl/pid_uk_accum.sv
// pid_uk_accum
// Sequencer for an incremental PID calculator. On each accepted measurement it
// forms a clamped, deadbanded error, shifts the ek0/ek1/ek2 history, captures
// the calculator's increment d_uk, scales it by an arithmetic right shift and
// accumulates it into a clamped absolute control value uk.
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst_n   synchronous active-low reset
//   pid_en      loop enable; low aborts any sequence and clears the history
//   meas_valid  one-cycle strobe for a new measurement
//   meas        measured position (unsigned 10b)
//   setpoint    target position (unsigned 10b)
//   ek0/ek1/ek2 signed error history driving the calculator
//   d_uk        signed increment from the combinational calculator
//   uk          absolute control value (unsigned 12b)
//   uk_valid    one-cycle pulse when uk updates
//   busy        high while the sequencer is not idle
//   drop_cnt    saturating count of strobes dropped while busy
module pid_uk_accum #(
  parameter int UK_INIT  = 2048,
  parameter int UK_MIN   = 0,
  parameter int UK_MAX   = 4095,
  parameter int DEADBAND = 2,
  parameter int SHIFT    = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pid_en,
  input  logic               meas_valid,
  input  logic [9:0]         meas,
  input  logic [9:0]         setpoint,
  output logic signed [9:0]  ek0,
  output logic signed [9:0]  ek1,
  output logic signed [9:0]  ek2,
  input  logic signed [14:0] d_uk,
  output logic [11:0]        uk,
  output logic               uk_valid,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPT, S_ACC} state_t;

  localparam logic signed [10:0] E_HI   = 11'sd511;
  localparam logic signed [10:0] E_LO   = -11'sd512;
  localparam logic signed [10:0] DB     = 11'(DEADBAND);
  localparam logic signed [16:0] UK_LO  = 17'(UK_MIN);
  localparam logic signed [16:0] UK_HI  = 17'(UK_MAX);
  localparam logic [11:0]        UK_RST = 12'(UK_INIT);

  state_t state, nxt;

  logic signed [10:0] e_raw;
  logic signed [9:0]  e_proc;
  logic signed [9:0]  e_r;
  logic signed [14:0] d_r;
  logic signed [14:0] d_sh;
  logic signed [16:0] sum;
  logic [11:0]        uk_nxt;

  // Error path: widen both operands so the difference never overflows,
  // clamp to the 10-bit history range, then apply the deadband.
  always_comb begin
    e_raw = $signed({1'b0, setpoint}) - $signed({1'b0, meas});
    if (e_raw >= -DB && e_raw <= DB) e_proc = '0;
    else if (e_raw > E_HI)           e_proc = 10'sd511;
    else if (e_raw < E_LO)           e_proc = -10'sd512;
    else                             e_proc = e_raw[9:0];
  end

  // Accumulate path: >>> on a signed operand floors toward -inf.
  always_comb begin
    d_sh = d_r >>> SHIFT;
    sum  = $signed({5'b0, uk}) + $signed({{2{d_sh[14]}}, d_sh});
    if (sum < UK_LO)      uk_nxt = UK_LO[11:0];
    else if (sum > UK_HI) uk_nxt = UK_HI[11:0];
    else                  uk_nxt = sum[11:0];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= nxt;
  end

  // Disable takes priority over every transition.
  always_comb begin
    nxt = state;
    if (!pid_en) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (meas_valid) nxt = S_SHIFT;
        S_SHIFT: nxt = S_CAPT;
        S_CAPT:  nxt = S_ACC;
        S_ACC:   nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ek0      <= '0;
      ek1      <= '0;
      ek2      <= '0;
      e_r      <= '0;
      d_r      <= '0;
      uk       <= UK_RST;
      uk_valid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      uk_valid <= 1'b0;
      if (pid_en && meas_valid && state != S_IDLE && drop_cnt != 8'hff)
        drop_cnt <= drop_cnt + 8'd1;
      if (!pid_en) begin
        ek0 <= '0;
        ek1 <= '0;
        ek2 <= '0;
      end else begin
        case (state)
          S_IDLE:  if (meas_valid) e_r <= e_proc;
          S_SHIFT: begin
            ek2 <= ek1;
            ek1 <= ek0;
            ek0 <= e_r;
          end
          // Calculator is combinational on ek*, so d_uk has settled a full
          // cycle after the history shift.
          S_CAPT:  d_r <= d_uk;
          S_ACC: begin
            uk       <= uk_nxt;
            uk_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pid_uk_accum.sv
module tb_pid_uk_accum;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               pid_en = 1'b0;
  logic               meas_valid = 1'b0;
  logic [9:0]         meas = '0;
  logic [9:0]         setpoint = '0;
  logic signed [9:0]  ek0, ek1, ek2;
  logic signed [14:0] d_uk;
  logic [11:0]        uk;
  logic               uk_valid;
  logic               busy;
  logic [7:0]         drop_cnt;

  int ntests = 0;
  int nfail  = 0;

  // sample observations
  logic signed [9:0]  o_ek0, o_ek1, o_ek2;
  logic signed [14:0] o_duk;
  logic [11:0]        o_uk;
  logic               o_busy, o_vld;
  int                 o_early;

  always #5 sys_clk = ~sys_clk;

  // Incremental calculator, kp=2 ki=1 kd=0.
  always_comb begin
    int t;
    t = 2 * (int'(ek0) - int'(ek1)) + int'(ek0);
    d_uk = t[14:0];
  end

  pid_uk_accum dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pid_en(pid_en),
    .meas_valid(meas_valid), .meas(meas), .setpoint(setpoint),
    .ek0(ek0), .ek1(ek1), .ek2(ek2), .d_uk(d_uk),
    .uk(uk), .uk_valid(uk_valid), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic do_reset();
    @(negedge sys_clk); sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Strobe one measurement and observe E0..E3 at the following falling edges.
  task automatic run_sample(input logic [9:0] sp, input logic [9:0] m);
    @(negedge sys_clk); setpoint = sp; meas = m; meas_valid = 1'b1;
    @(negedge sys_clk); meas_valid = 1'b0; o_busy = busy; o_early = int'(uk_valid);
    @(negedge sys_clk); o_ek0 = ek0; o_ek1 = ek1; o_ek2 = ek2; o_duk = d_uk;
    o_early += int'(uk_valid);
    @(negedge sys_clk); o_early += int'(uk_valid);
    @(negedge sys_clk); o_vld = uk_valid; o_uk = uk;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge sys_clk);
    ntests++; if (uk !== 12'd2048) begin nfail++; $display("FAIL reset_uk got %0d exp 2048", uk); end
    ntests++; if (ek0 !== 0 || ek1 !== 0 || ek2 !== 0) begin nfail++; $display("FAIL reset_ek got %0d/%0d/%0d exp 0/0/0", ek0, ek1, ek2); end
    ntests++; if (uk_valid !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL reset_flags got vld=%b busy=%b exp 0/0", uk_valid, busy); end
    ntests++; if (drop_cnt !== 8'd0) begin nfail++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_basic();
    pid_en = 1'b1;
    run_sample(10'd320, 10'd300);
    ntests++; if (o_busy !== 1'b1) begin nfail++; $display("FAIL basic1_busy got %b exp 1", o_busy); end
    ntests++; if (o_ek0 !== 10'sd20 || o_ek1 !== 10'sd0) begin nfail++; $display("FAIL basic1_ek got %0d/%0d exp 20/0", o_ek0, o_ek1); end
    ntests++; if (o_duk !== 15'sd60) begin nfail++; $display("FAIL basic1_duk got %0d exp 60", o_duk); end
    ntests++; if (o_early !== 0 || o_vld !== 1'b1) begin nfail++; $display("FAIL basic1_latency got early=%0d vld=%b exp 0/1", o_early, o_vld); end
    ntests++; if (o_uk !== 12'd2055) begin nfail++; $display("FAIL basic1_uk got %0d exp 2055", o_uk); end
    @(negedge sys_clk);
    ntests++; if (uk_valid !== 1'b0) begin nfail++; $display("FAIL basic1_pulse got %b exp 0", uk_valid); end
    run_sample(10'd320, 10'd310);
    ntests++; if (o_ek0 !== 10'sd10 || o_ek1 !== 10'sd20 || o_ek2 !== 10'sd0) begin nfail++; $display("FAIL basic2_ek got %0d/%0d/%0d exp 10/20/0", o_ek0, o_ek1, o_ek2); end
    ntests++; if (o_duk !== -15'sd10) begin nfail++; $display("FAIL basic2_duk got %0d exp -10", o_duk); end
    ntests++; if (o_uk !== 12'd2053 || o_vld !== 1'b1) begin nfail++; $display("FAIL basic2_uk got %0d vld=%b exp 2053/1", o_uk, o_vld); end
  endtask

  task automatic test_deadband_clamp();
    // Disable briefly to clear the history.
    @(negedge sys_clk); pid_en = 1'b0;
    @(negedge sys_clk); pid_en = 1'b1;
    ntests++; if (ek0 !== 0 || ek1 !== 0) begin nfail++; $display("FAIL clr_ek got %0d/%0d exp 0/0", ek0, ek1); end
    run_sample(10'd320, 10'd319);
    ntests++; if (o_ek0 !== 10'sd0 || o_duk !== 15'sd0) begin nfail++; $display("FAIL dband got ek0=%0d duk=%0d exp 0/0", o_ek0, o_duk); end
    ntests++; if (o_uk !== 12'd2053 || o_vld !== 1'b1) begin nfail++; $display("FAIL dband_uk got %0d vld=%b exp 2053/1", o_uk, o_vld); end
    run_sample(10'd1023, 10'd0);
    ntests++; if (o_ek0 !== 10'sd511 || o_duk !== 15'sd1533) begin nfail++; $display("FAIL clamp got ek0=%0d duk=%0d exp 511/1533", o_ek0, o_duk); end
    ntests++; if (o_uk !== 12'd2244) begin nfail++; $display("FAIL clamp_uk got %0d exp 2244", o_uk); end
  endtask

  task automatic test_saturate();
    logic [11:0] prev;
    int bad;
    prev = uk; bad = 0;
    // +63 per sample from 2244: reaches the ceiling after 30 samples.
    for (int i = 0; i < 35; i++) begin
      run_sample(10'd1023, 10'd0);
      if (o_uk < prev) bad++;
      prev = o_uk;
    end
    ntests++; if (bad !== 0) begin nfail++; $display("FAIL sat_hi_mono got %0d drops exp 0", bad); end
    ntests++; if (o_uk !== 12'd4095) begin nfail++; $display("FAIL sat_hi got %0d exp 4095", o_uk); end
    bad = 0;
    // First sample -320 (d=-2558), then -64 each: floor reached well before 80.
    for (int i = 0; i < 80; i++) begin
      run_sample(10'd0, 10'd1023);
      if (i == 0 && o_uk !== 12'd3775) bad++;
      if (o_uk > prev) bad++;
      prev = o_uk;
    end
    ntests++; if (bad !== 0) begin nfail++; $display("FAIL sat_lo_mono got %0d errs exp 0", bad); end
    ntests++; if (o_uk !== 12'd0 || o_ek0 !== -10'sd512) begin nfail++; $display("FAIL sat_lo got uk=%0d ek0=%0d exp 0/-512", o_uk, o_ek0); end
  endtask

  task automatic test_back_to_back();
    int nv;
    do_reset();
    pid_en = 1'b1; setpoint = 10'd500; meas = 10'd500;
    @(negedge sys_clk); meas_valid = 1'b1;
    repeat (2) @(negedge sys_clk);
    meas_valid = 1'b0; nv = 0;
    for (int i = 0; i < 6; i++) begin
      nv += int'(uk_valid);
      @(negedge sys_clk);
    end
    ntests++; if (nv !== 1) begin nfail++; $display("FAIL b2b_vld got %0d exp 1", nv); end
    ntests++; if (drop_cnt !== 8'd1) begin nfail++; $display("FAIL b2b_drop got %0d exp 1", drop_cnt); end
    meas_valid = 1'b1;
    repeat (420) @(negedge sys_clk);
    meas_valid = 1'b0;
    repeat (6) @(negedge sys_clk);
    ntests++; if (drop_cnt !== 8'd255) begin nfail++; $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
  endtask

  task automatic test_abort();
    int nv;
    do_reset();
    pid_en = 1'b1;
    run_sample(10'd320, 10'd300);
    @(negedge sys_clk); setpoint = 10'd320; meas = 10'd310; meas_valid = 1'b1;
    @(negedge sys_clk); meas_valid = 1'b0; nv = int'(uk_valid);
    @(negedge sys_clk); pid_en = 1'b0;  // FSM now in CAPT
    @(negedge sys_clk);
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL abort_busy got %b exp 0", busy); end
    ntests++; if (ek0 !== 0 || ek1 !== 0 || ek2 !== 0) begin nfail++; $display("FAIL abort_ek got %0d/%0d/%0d exp 0/0/0", ek0, ek1, ek2); end
    for (int i = 0; i < 4; i++) begin
      nv += int'(uk_valid);
      @(negedge sys_clk);
    end
    ntests++; if (nv !== 0 || uk !== 12'd2055) begin nfail++; $display("FAIL abort_uk got uk=%0d vld=%0d exp 2055/0", uk, nv); end
    // Strobe while disabled: ignored, not counted.
    meas_valid = 1'b1;
    @(negedge sys_clk); meas_valid = 1'b0;
    ntests++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin nfail++; $display("FAIL dis_strobe got busy=%b drop=%0d exp 0/0", busy, drop_cnt); end
  endtask

  task automatic test_reset_in_acc();
    pid_en = 1'b1;
    run_sample(10'd320, 10'd300);
    @(negedge sys_clk); meas = 10'd310; meas_valid = 1'b1;
    @(negedge sys_clk); meas_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b0;  // FSM now in ACC
    @(negedge sys_clk);
    ntests++; if (uk !== 12'd2048 || uk_valid !== 1'b0) begin nfail++; $display("FAIL rst_acc got uk=%0d vld=%b exp 2048/0", uk, uk_valid); end
    ntests++; if (busy !== 1'b0 || ek0 !== 0) begin nfail++; $display("FAIL rst_acc_state got busy=%b ek0=%0d exp 0/0", busy, ek0); end
    sys_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deadband_clamp();
    test_saturate();
    test_back_to_back();
    test_abort();
    test_reset_in_acc();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
